// File: rtl/cam_pkg.sv
// Shared types and pixel conversion for the camera capture engine.
// The conversion helper takes bytes in high/low order; the caller resolves byte order.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRM,
        ST_LINE,
        ST_DONE
    } cam_state_t;

    localparam int PIX_FMT_RGB565 = 0;
    localparam int PIX_FMT_RGB444 = 1;

    // hi_byte/lo_byte are the high and low halves of the 16-bit camera pixel.
    function automatic logic [7:0] rgb_to_332(input logic [7:0] hi_byte,
                                              input logic [7:0] lo_byte,
                                              input int         fmt);
        logic [7:0] pix;
        if (fmt == PIX_FMT_RGB444) begin
            pix = {hi_byte[3:1], lo_byte[7:5], lo_byte[3:2]};
        end else begin
            pix = {hi_byte[7:5], hi_byte[2:0], lo_byte[4:3]};
        end
        return pix;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// N-stage synchroniser for one camera control line, with rise/fall strobes
// taken from the last synchronised stage.
module cam_sync_edge
    import cam_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              q_prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= '0;
            q_prev_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[STAGES-2:0], din};
            q_prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign q    = sync_reg[STAGES-1];
    assign rise = sync_reg[STAGES-1] & ~q_prev_reg;
    assign fall = ~sync_reg[STAGES-1] & q_prev_reg;

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670-style capture engine: samples the camera bus in the system clock domain,
// packs byte pairs into RGB332 and emits framebuffer writes with frame bookkeeping.
module cam_frame_capture
    import cam_pkg::*;
#(
    parameter int IMG_W       = 176,
    parameter int IMG_H       = 144,
    parameter int ADDR_W      = 15,
    parameter int SYNC_STAGES = 2,
    parameter int PIX_FMT     = 0,
    parameter int BYTE_SWAP   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CAM_PCLK,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    input  logic [7:0]        CAM_D,
    input  logic              CAPTURE_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic [7:0]        FRAME_CNT,
    output logic              LINE_ERR,
    output logic              BUSY
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    // Control lines: bit 0 = PCLK, bit 1 = HREF, bit 2 = VSYNC.
    logic [2:0] ctl_raw, ctl_q, ctl_rise, ctl_fall;
    assign ctl_raw = {CAM_VSYNC, CAM_HREF, CAM_PCLK};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        cam_sync_edge #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (CLK),
            .srst(RESET),
            .din (ctl_raw[gi]),
            .q   (ctl_q[gi]),
            .rise(ctl_rise[gi]),
            .fall(ctl_fall[gi])
        );
    end

    // Data byte gets the same delay so it lines up with the synced PCLK edge.
    logic [7:0] d_pipe_reg [SYNC_STAGES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) d_pipe_reg[i] <= '0;
        end else begin
            d_pipe_reg[0] <= CAM_D;
            for (int i = 1; i < SYNC_STAGES; i++) d_pipe_reg[i] <= d_pipe_reg[i-1];
        end
    end

    logic [7:0] d_sync;
    logic       pclk_rise, href_lvl, href_fall, vs_rise, vs_fall;
    logic       unused_ctl;

    assign d_sync     = d_pipe_reg[SYNC_STAGES-1];
    assign pclk_rise  = ctl_rise[0];
    assign href_lvl   = ctl_q[1];
    assign href_fall  = ctl_fall[1];
    assign vs_rise    = ctl_rise[2];
    assign vs_fall    = ctl_fall[2];
    assign unused_ctl = ^{ctl_q[0], ctl_q[2], ctl_fall[0], ctl_rise[1]};

    cam_state_t        state_reg, state_next;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              phase_lo_reg;
    logic [7:0]        byte0_reg;
    logic              w_en_reg;
    logic [ADDR_W-1:0] w_addr_reg;
    logic [7:0]        w_data_reg;
    logic [7:0]        frame_cnt_reg;
    logic              line_err_reg;

    always_comb begin
        state_next = state_reg;
        FRAME_DONE = 1'b0;
        BUSY       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CAPTURE_EN) state_next = ST_WAIT_FRM;
            end
            ST_WAIT_FRM: begin
                if (vs_fall) state_next = ST_LINE;
            end
            ST_LINE: begin
                BUSY = 1'b1;
                if (vs_rise) state_next = ST_DONE;
            end
            ST_DONE: begin
                FRAME_DONE = 1'b1;
                state_next = CAPTURE_EN ? ST_WAIT_FRM : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // End of frame takes priority over any line or pixel event in the same cycle.
    logic       line_active;
    logic       in_bounds;
    logic [7:0] hi_byte, lo_byte, pix_next;

    assign line_active = (state_reg == ST_LINE) && !vs_rise;
    assign in_bounds   = (x_reg < XW'(IMG_W)) && (y_reg < YW'(IMG_H));
    assign hi_byte     = (BYTE_SWAP != 0) ? d_sync : byte0_reg;
    assign lo_byte     = (BYTE_SWAP != 0) ? byte0_reg : d_sync;
    assign pix_next    = rgb_to_332(hi_byte, lo_byte, PIX_FMT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            base_reg      <= '0;
            phase_lo_reg  <= 1'b0;
            byte0_reg     <= '0;
            w_en_reg      <= 1'b0;
            w_addr_reg    <= '0;
            w_data_reg    <= '0;
            frame_cnt_reg <= '0;
            line_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_en_reg  <= 1'b0;

            if (state_reg == ST_WAIT_FRM && vs_fall) begin
                x_reg        <= '0;
                y_reg        <= '0;
                base_reg     <= '0;
                phase_lo_reg <= 1'b0;
            end

            if (state_reg == ST_LINE && vs_rise) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end

            if (line_active) begin
                if (href_fall) begin
                    if (phase_lo_reg) line_err_reg <= 1'b1;
                    phase_lo_reg <= 1'b0;
                    x_reg        <= '0;
                    // y stops at IMG_H so late lines never alias back into the frame.
                    if (y_reg < YW'(IMG_H)) begin
                        y_reg    <= y_reg + YW'(1);
                        base_reg <= base_reg + ADDR_W'(IMG_W);
                    end
                end else if (pclk_rise && href_lvl) begin
                    if (!phase_lo_reg) begin
                        byte0_reg    <= d_sync;
                        phase_lo_reg <= 1'b1;
                    end else begin
                        phase_lo_reg <= 1'b0;
                        if (in_bounds) begin
                            w_en_reg   <= 1'b1;
                            w_addr_reg <= base_reg + ADDR_W'(x_reg);
                            w_data_reg <= pix_next;
                        end
                        if (x_reg < XW'(IMG_W)) x_reg <= x_reg + XW'(1);
                    end
                end
            end
        end
    end

    assign W_EN      = w_en_reg;
    assign W_ADDR    = w_addr_reg;
    assign W_DATA    = w_data_reg;
    assign FRAME_CNT = frame_cnt_reg;
    assign LINE_ERR  = line_err_reg;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Scoreboard bench: stimulus queues expected writes per instance, a monitor
// pops and compares on every W_EN. Four instances cover formats, byte swap and bounds.
module tb_cam_frame_capture;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cam_pclk, cam_href, cam_vsync, capture_en;
    logic [7:0] cam_d;

    logic        w_en       [4];
    logic [14:0] w_addr     [3];
    logic [4:0]  w_addr3;
    logic [7:0]  w_data     [4];
    logic        frame_done [4];
    logic [7:0]  frame_cnt  [4];
    logic        line_err   [4];
    logic        busy       [4];

    exp_t sb_q [4][$];
    int   img_w [4] = '{176, 176, 176, 6};
    int   img_h [4] = '{144, 144, 144, 4};
    int   wr_cnt   [4] = '{0, 0, 0, 0};
    int   max_addr [4] = '{0, 0, 0, 0};

    int   errors = 0;
    int   checks = 0;
    int   px = 0;
    int   ln = 0;
    int   exp_cnt = 0;
    logic cap_exp = 1'b0;

    cam_frame_capture u_565 (
        .CLK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href),
        .CAM_VSYNC(cam_vsync), .CAM_D(cam_d), .CAPTURE_EN(capture_en),
        .W_ADDR(w_addr[0]), .W_DATA(w_data[0]), .W_EN(w_en[0]),
        .FRAME_DONE(frame_done[0]), .FRAME_CNT(frame_cnt[0]),
        .LINE_ERR(line_err[0]), .BUSY(busy[0])
    );

    cam_frame_capture #(.PIX_FMT(1)) u_444 (
        .CLK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href),
        .CAM_VSYNC(cam_vsync), .CAM_D(cam_d), .CAPTURE_EN(capture_en),
        .W_ADDR(w_addr[1]), .W_DATA(w_data[1]), .W_EN(w_en[1]),
        .FRAME_DONE(frame_done[1]), .FRAME_CNT(frame_cnt[1]),
        .LINE_ERR(line_err[1]), .BUSY(busy[1])
    );

    cam_frame_capture #(.PIX_FMT(1), .BYTE_SWAP(1)) u_444s (
        .CLK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href),
        .CAM_VSYNC(cam_vsync), .CAM_D(cam_d), .CAPTURE_EN(capture_en),
        .W_ADDR(w_addr[2]), .W_DATA(w_data[2]), .W_EN(w_en[2]),
        .FRAME_DONE(frame_done[2]), .FRAME_CNT(frame_cnt[2]),
        .LINE_ERR(line_err[2]), .BUSY(busy[2])
    );

    cam_frame_capture #(.IMG_W(6), .IMG_H(4), .ADDR_W(5)) u_small (
        .CLK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href),
        .CAM_VSYNC(cam_vsync), .CAM_D(cam_d), .CAPTURE_EN(capture_en),
        .W_ADDR(w_addr3), .W_DATA(w_data[3]), .W_EN(w_en[3]),
        .FRAME_DONE(frame_done[3]), .FRAME_CNT(frame_cnt[3]),
        .LINE_ERR(line_err[3]), .BUSY(busy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    // Write monitor: one line per observed write.
    always @(negedge clk) begin : mon
        int   a;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (w_en[i]) begin
                a = (i == 3) ? int'(w_addr3) : int'(w_addr[i]);
                wr_cnt[i]++;
                if (a > max_addr[i]) max_addr[i] = a;
                checks++;
                if (sb_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected u%0d: W_ADDR=%0d W_DATA=%02h, required no write", i, a, w_data[i]);
                end else begin
                    e = sb_q[i].pop_front();
                    if (a != e.addr || w_data[i] !== e.data) begin
                        errors++;
                        $display("FAIL wr_u%0d: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 i, a, w_data[i], e.addr, e.data);
                    end else begin
                        $display("%0t wr u%0d addr=%0d data=%02h ok", $time, i, a, w_data[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_d    = b;
        cam_pclk = 1'b0;
        cyc(1);
        cam_pclk = 1'b1;
        cyc(1);
    endtask

    // Expected RGB332 for the 565, 444 and 444-swapped instances (small one is 565).
    task automatic pixel(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] e565, input logic [7:0] e444, input logic [7:0] e444s);
        logic [7:0] ev [4];
        ev[0] = e565; ev[1] = e444; ev[2] = e444s; ev[3] = e565;
        cam_byte(b0);
        cam_byte(b1);
        for (int i = 0; i < 4; i++) begin
            if (cap_exp && px < img_w[i] && ln < img_h[i])
                sb_q[i].push_back('{ln * img_w[i] + px, ev[i]});
        end
        px++;
    endtask

    task automatic line_start();
        cam_href = 1'b1;
        px = 0;
        cyc(1);
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cyc(3);
        ln++;
    endtask

    task automatic frame_start();
        cam_vsync = 1'b0;
        ln = 0;
        cyc(4);
        chk("busy_at_frame_start", busy[0], int'(cap_exp));
    endtask

    task automatic frame_end(input logic expect_done);
        logic seen;
        seen = 1'b0;
        cam_vsync = 1'b1;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (frame_done[0]) seen = 1'b1;
        end
        if (expect_done) begin
            exp_cnt = (exp_cnt + 1) % 256;
            chk("frame_done_pulse", int'(seen), 1);
            chk("frame_cnt", int'(frame_cnt[0]), exp_cnt);
            chk("frame_cnt_small", int'(frame_cnt[3]), exp_cnt);
            chk("busy_at_done", int'(busy[0]), 0);
            @(negedge clk);
            chk("frame_done_width", int'(frame_done[0]), 0);
        end else begin
            chk("no_frame_done", int'(seen), 0);
        end
        @(posedge clk);
        #1;
        cyc(2);
    endtask

    initial begin : stim
        int base3;
        rst        = 1'b1;
        cam_pclk   = 1'b0;
        cam_href   = 1'b0;
        cam_vsync  = 1'b1;
        cam_d      = 8'h00;
        capture_en = 1'b0;
        cyc(5);
        rst = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_w_en", int'(w_en[0]), 0);
        chk("rst_w_addr", int'(w_addr[0]), 0);
        chk("rst_w_data", int'(w_data[0]), 0);
        chk("rst_frame_done", int'(frame_done[0]), 0);
        chk("rst_frame_cnt", int'(frame_cnt[0]), 0);
        chk("rst_line_err", int'(line_err[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);

        // 2-line frame with format vectors
        capture_en = 1'b1;
        cyc(2);
        cap_exp = 1'b1;
        frame_start();
        line_start();
        pixel(8'hF8, 8'h00, 8'hE0, 8'h80, 8'h1E);
        pixel(8'h07, 8'hE0, 8'h1C, 8'h7C, 8'h01);
        line_end();
        line_start();
        pixel(8'h0F, 8'h00, 8'h1C, 8'hE0, 8'h03);
        pixel(8'h00, 8'hF0, 8'h02, 8'h1C, 8'h00);
        pixel(8'h00, 8'h0F, 8'h01, 8'h03, 8'hE0);
        line_end();
        frame_end(1'b1);
        chk("line_err_clean", int'(line_err[0]), 0);

        // Odd byte count on a line
        frame_start();
        line_start();
        pixel(8'hF8, 8'h00, 8'hE0, 8'h80, 8'h1E);
        cam_byte(8'h07);
        line_end();
        chk("line_err_set", int'(line_err[0]), 1);
        chk("line_err_set_small", int'(line_err[3]), 1);
        line_start();
        pixel(8'h07, 8'hE0, 8'h1C, 8'h7C, 8'h01);
        line_end();
        frame_end(1'b1);
        chk("line_err_sticky", int'(line_err[0]), 1);

        // Oversized frame: 8 pixels x 6 lines against the 6x4 instance
        base3 = wr_cnt[3];
        frame_start();
        for (int l = 0; l < 6; l++) begin
            line_start();
            for (int p = 0; p < 8; p++) pixel(8'hF8, 8'h00, 8'hE0, 8'h80, 8'h1E);
            line_end();
        end
        frame_end(1'b1);
        cyc(3);
        chk("bounds_write_count", wr_cnt[3] - base3, 24);
        chk("bounds_max_addr", max_addr[3], 23);

        // Reset mid-line with a write pending, released while HREF is high
        frame_start();
        line_start();
        pixel(8'hF8, 8'h00, 8'hE0, 8'h80, 8'h1E);
        cam_byte(8'h07);
        cam_d    = 8'hE0;
        cam_pclk = 1'b0;
        cyc(1);
        cam_pclk = 1'b1;
        cyc(2);
        rst = 1'b1;
        cap_exp = 1'b0;
        exp_cnt = 0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("midrst_w_en", int'(w_en[0]), 0);
        chk("midrst_line_err", int'(line_err[0]), 0);
        chk("midrst_frame_cnt", int'(frame_cnt[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        pixel(8'h0F, 8'h00, 8'h1C, 8'hE0, 8'h03);
        pixel(8'h00, 8'hF0, 8'h02, 8'h1C, 8'h00);
        line_end();
        line_start();
        pixel(8'h0F, 8'h00, 8'h1C, 8'hE0, 8'h03);
        line_end();
        frame_end(1'b0);
        cap_exp = 1'b1;
        frame_start();
        line_start();
        pixel(8'h07, 8'hE0, 8'h1C, 8'h7C, 8'h01);
        line_end();
        frame_end(1'b1);

        // CAPTURE_EN dropped mid-frame
        frame_start();
        line_start();
        pixel(8'h0F, 8'h00, 8'h1C, 8'hE0, 8'h03);
        line_end();
        capture_en = 1'b0;
        line_start();
        pixel(8'h00, 8'hF0, 8'h02, 8'h1C, 8'h00);
        line_end();
        frame_end(1'b1);
        cap_exp = 1'b0;
        frame_start();
        line_start();
        pixel(8'hF8, 8'h00, 8'hE0, 8'h80, 8'h1E);
        line_end();
        frame_end(1'b0);

        // Empty frames up to the counter wrap
        capture_en = 1'b1;
        cyc(2);
        cap_exp = 1'b1;
        while (exp_cnt != 255) begin
            frame_start();
            frame_end(1'b1);
        end
        chk("frame_cnt_255", int'(frame_cnt[0]), 255);
        frame_start();
        frame_end(1'b1);
        chk("frame_cnt_wrap", int'(frame_cnt[0]), 0);

        cyc(5);
        for (int i = 0; i < 4; i++) chk($sformatf("sb_empty_u%0d", i), sb_q[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
